encode_var_seq: RTL



---
 rtl/encode_var_seq_pkg.sv | 28 ++
 rtl/enc_lsb_find.sv | 27 ++
 rtl/encode_var_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/encode_var_seq_pkg.sv
// encode_var_seq_pkg: shared definitions for the variable-width binary encode/decode family.
//   - enc_state_e        : sequencer state encoding (ST_IDLE, ST_EMIT)
//   - DATA_BITS_DEFAULT  : default index width
//   - DCD_BITS_DEFAULT   : default vector width
//   - ENC_VAR_WIDTH_CHECK: elaboration guard, DCD_BITS must equal 2**DATA_BITS

`ifndef ENCODE_VAR_SEQ_PKG_SV
`define ENCODE_VAR_SEQ_PKG_SV

// Use inside a module body; elaboration stops when the widths disagree.
`define ENC_VAR_WIDTH_CHECK(DB, CB) \
    if ((CB) != (1 << (DB))) begin : g_width_check \
        $error("DCD_BITS must equal 2**DATA_BITS"); \
    end

package encode_var_seq_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 4;
    localparam int unsigned DCD_BITS_DEFAULT  = 1 << DATA_BITS_DEFAULT;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_e;

endpackage

`endif

// File: rtl/enc_lsb_find.sv
// enc_lsb_find: combinational lowest-set-bit finder.
//   vec_i  [DCD_BITS]  : input vector
//   idx_o  [DATA_BITS] : index of the lowest set bit (0 when vec_i is all zero)
//   any_o              : at least one bit of vec_i is set

module enc_lsb_find #(
    parameter int unsigned DATA_BITS = 4,
    parameter int unsigned DCD_BITS  = 16
) (
    input  logic [DCD_BITS-1:0]  vec_i,
    output logic [DATA_BITS-1:0] idx_o,
    output logic                 any_o
);

    // Scan from the top down so the lowest set bit is the last to write idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = int'(DCD_BITS) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = DATA_BITS'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/encode_var_seq.sv
// encode_var_seq: latches a one-/multi-hot vector and streams the index of each set bit,
// lowest first, one per valid/ready beat.
//   clk, rst_n            : clock, asynchronous active-low reset
//   dcd_in/valid/ready    : input vector handshake (accepts only in IDLE)
//   data_out/valid/ready  : binary index stream
//   data_last             : current beat is the final set bit of the vector
//   zero_err              : one-cycle pulse after an all-zero vector is accepted
//   busy                  : high while emitting

module encode_var_seq
    import encode_var_seq_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT,
    parameter int unsigned DCD_BITS  = DCD_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DCD_BITS-1:0]  dcd_in,
    input  logic                 dcd_valid,
    output logic                 dcd_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 data_last,
    output logic                 zero_err,
    output logic                 busy
);

    `ENC_VAR_WIDTH_CHECK(DATA_BITS, DCD_BITS)

    enc_state_e           state_q;
    logic [DCD_BITS-1:0]  pending_q;
    logic                 zero_err_q;

    logic [DATA_BITS-1:0] lsb_idx;
    logic                 lsb_any;
    logic [DCD_BITS-1:0]  lsb_mask;
    logic                 single;

    enc_lsb_find #(
        .DATA_BITS (DATA_BITS),
        .DCD_BITS  (DCD_BITS)
    ) u_lsb_find (
        .vec_i (pending_q),
        .idx_o (lsb_idx),
        .any_o (lsb_any)
    );

    assign lsb_mask = DCD_BITS'(1) << lsb_idx;
    // Exactly one bit left: clearing the lowest leaves nothing.
    assign single   = lsb_any && ((pending_q & ~lsb_mask) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            zero_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (dcd_valid) begin
                        if (dcd_in != '0) begin
                            pending_q <= dcd_in;
                            state_q   <= ST_EMIT;
                        end else begin
                            zero_err_q <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (data_ready) begin
                        pending_q <= pending_q & ~lsb_mask;
                        if (single) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // All outputs derive from state_q/pending_q/zero_err_q only.
    assign dcd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_EMIT);
    assign data_valid = (state_q == ST_EMIT);
    assign data_out   = lsb_idx;
    assign data_last  = (state_q == ST_EMIT) && single;
    assign zero_err   = zero_err_q;

endmodule
